mux_2x1_rr: RTL and testbench

MUX_2X1_RR -- requirements
Module: mux_2x1_rr

---
 rtl/mux_2x1_rr.sv | 58 +++++
 tb/tb_mux_2x1_rr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_rr.sv
// Two-channel round-robin merge into a single registered output slot.
// Full-throughput valid/ready on both sides; channel 0 wins first contention.
module mux_2x1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic             d0_valid,
    output logic             d0_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic             d1_valid,
    output logic             d1_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel
);

    logic last;
    logic free;
    logic grant;
    logic accept;

    assign free = ~y_valid | y_ready;

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            d0_valid & ~d1_valid: grant = 1'b0;
            ~d0_valid & d1_valid: grant = 1'b1;
            d0_valid & d1_valid:  grant = ~last;
            default:              grant = 1'b0;
        endcase
    end

    // rst_n gating keeps both readies low for the whole reset window
    assign d0_ready = rst_n & free & ~grant & d0_valid;
    assign d1_ready = rst_n & free & grant & d1_valid;
    assign accept   = d0_ready | d1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            sel     <= 1'b0;
            y_valid <= 1'b0;
            last    <= 1'b1;
        end else if (accept) begin
            y       <= grant ? d1 : d0;
            sel     <= grant;
            y_valid <= 1'b1;
            last    <= grant;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_2x1_rr.sv
// Randomized and directed bench for mux_2x1_rr against a
// behavioural reference model with per-channel beat queues.
module tb_mux_2x1_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d0, d1, y;
    logic       d0_valid, d1_valid, d0_ready, d1_ready;
    logic       y_valid, y_ready, sel;

    int errs = 0;
    int checks = 0;

    // model state: held beat and the channel that wins the next contention
    logic       m_valid;
    logic [7:0] m_y;
    logic       m_sel;
    logic       m_turn;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    mux_2x1_rr #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .d0(d0), .d0_valid(d0_valid), .d0_ready(d0_ready),
        .d1(d1), .d1_valid(d1_valid), .d1_ready(d1_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = 8'h00;
        m_sel   = 1'b0;
        m_turn  = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    // Called just after a rising edge: drive, compare, advance one edge.
    task automatic cyc(input logic v0, input logic [7:0] a0,
                       input logic v1, input logic [7:0] a1,
                       input logic yr);
        logic space, e0, e1;
        logic [7:0] front;
        d0_valid = v0; d0 = a0;
        d1_valid = v1; d1 = a1;
        y_ready  = yr;
        #1;
        space = rst_n && (!m_valid || yr);
        e0 = 1'b0;
        e1 = 1'b0;
        if (space) begin
            if (v0 && v1) begin
                e0 = (m_turn == 1'b0);
                e1 = (m_turn == 1'b1);
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        check("d0_ready", d0_ready, e0);
        check("d1_ready", d1_ready, e1);
        check("y_valid", y_valid, m_valid);
        check("y", y, m_y);
        check("sel", sel, m_sel);
        if (rst_n && m_valid && yr) begin
            if (m_sel) begin
                check("q1_nonempty", q1.size() > 0, 1);
                front = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
            end else begin
                check("q0_nonempty", q0.size() > 0, 1);
                front = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
            end
            check("sb_order", y, front);
        end
        @(posedge clk);
        if (rst_n) begin
            if (e0 || e1) begin
                m_y     = e1 ? a1 : a0;
                m_sel   = e1;
                m_valid = 1'b1;
                m_turn  = ~e1;
                if (e1) q1.push_back(a1);
                else    q0.push_back(a0);
            end else if (m_valid && yr) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [7:0] seq [4];
        logic       seq_s [4];
        int         n;
        rst_n = 1'b0;
        d0 = 8'h00; d1 = 8'h00;
        d0_valid = 1'b0; d1_valid = 1'b0; y_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // reset holds everything quiet even with both channels valid
        cyc(1'b1, 8'h5A, 1'b1, 8'h6B, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1, 8'h6B, 1'b1);
        check("rst_y_valid", y_valid, 0);
        check("rst_y", y, 0);
        check("rst_sel", sel, 0);
        rst_n = 1'b1;

        // single channel service
        cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        check("single0_y", y, 8'hA5);
        check("single0_sel", sel, 0);
        check("single0_vld", y_valid, 1);
        cyc(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1);
        check("single1_y", y, 8'h3C);
        check("single1_sel", sel, 1);

        // contention alternates without gaps
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
            seq[i] = y;
            seq_s[i] = sel;
            check("cont_vld", y_valid, 1);
        end
        check("cont_y0", seq[0], 8'h11);
        check("cont_y1", seq[1], 8'h22);
        check("cont_y2", seq[2], 8'h11);
        check("cont_y3", seq[3], 8'h22);
        check("cont_s0", seq_s[0], 0);
        check("cont_s1", seq_s[1], 1);
        check("cont_s2", seq_s[2], 0);
        check("cont_s3", seq_s[3], 1);

        // back-pressure
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        check("bp_load", y, 8'h11);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
            check("bp_hold_y", y, 8'h11);
            check("bp_hold_vld", y_valid, 1);
        end
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        check("bp_next_y", y, 8'h22);
        check("bp_next_sel", sel, 1);

        // asynchronous reset between edges while a beat is held
        check("ar_pre_vld", y_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_y_valid", y_valid, 0);
        check("ar_y", y, 0);
        check("ar_d0_ready", d0_ready, 0);
        check("ar_d1_ready", d1_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
        check("ar_first_y", y, 8'h77);
        check("ar_first_sel", sel, 0);

        // randomized traffic
        for (int i = 0; i < 1000; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), 8'($urandom),
                1'($urandom_range(0, 2) != 0), 8'($urandom),
                1'($urandom_range(0, 3) != 0));
        end

        // drain and confirm nothing left unobserved
        n = 0;
        while ((m_valid || q0.size() > 0 || q1.size() > 0) && n < 8) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            n++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        check("drain_vld", y_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
